// File: rtl/ps2_kbd_pkg.sv
// Shared constants, receiver state encoding and parity helper for the PS/2
// keyboard front end.
package ps2_kbd_pkg;

  localparam logic [7:0]  PS2_BREAK        = 8'hF0;
  localparam logic [7:0]  PS2_EXT          = 8'hE0;
  localparam logic [7:0]  SC_SPACE         = 8'h29;
  localparam logic [31:0] KBD_ADDR_DEFAULT = 32'h0000_0028;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // True when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_kbd_mmio_writer_rx.sv
// PS/2 frame receiver: input synchronizers, ps2_clk glitch filter, 11-bit
// frame FSM with an in-frame inactivity watchdog.
module ps2_rx
  import ps2_kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       rx_stb,
  output logic [7:0] rx_byte,
  output logic       rx_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT_CYCLES - 1);

  logic          clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
  logic          clk_filt_r, fall_stb_r;
  logic [FW-1:0] filt_cnt_r;

  rx_state_t     state_r, state_s;
  logic [2:0]    bit_cnt_r, bit_cnt_s;
  logic [7:0]    shift_r, shift_s;
  logic          par_r, par_s;
  logic [WW-1:0] wd_r, wd_s;
  logic          stb_r, stb_s, err_r, err_s;
  logic [7:0]    byte_r, byte_s;

  // Synchronizers and filter: a level change is taken only after FILTER_LEN stable cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
      clk_filt_r  <= 1'b1;
      filt_cnt_r  <= {FW{1'b0}};
      fall_stb_r  <= 1'b0;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
      fall_stb_r  <= 1'b0;
      if (clk_sync_r != clk_filt_r) begin
        if (filt_cnt_r == FILT_MAX) begin
          clk_filt_r <= clk_sync_r;
          filt_cnt_r <= {FW{1'b0}};
          fall_stb_r <= ~clk_sync_r;
        end else begin
          filt_cnt_r <= filt_cnt_r + FW'(1);
        end
      end else begin
        filt_cnt_r <= {FW{1'b0}};
      end
    end
  end

  // Frame state and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      par_r     <= 1'b0;
      wd_r      <= {WW{1'b0}};
      stb_r     <= 1'b0;
      err_r     <= 1'b0;
      byte_r    <= 8'h00;
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
      par_r     <= par_s;
      wd_r      <= wd_s;
      stb_r     <= stb_s;
      err_r     <= err_s;
      byte_r    <= byte_s;
    end
  end

  // Frame decoding on filtered falling edges, plus the watchdog.
  always_comb begin
    state_s   = state_r;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    par_s     = par_r;
    wd_s      = wd_r;
    stb_s     = 1'b0;
    err_s     = 1'b0;
    byte_s    = byte_r;
    case (state_r)
      IDLE: begin
        if (fall_stb_r) begin
          if (!data_sync_r) begin
            state_s   = DATA;
            bit_cnt_s = 3'd0;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      DATA: begin
        if (fall_stb_r) begin
          shift_s = {data_sync_r, shift_r[7:1]};
          if (bit_cnt_r == 3'd7) begin
            state_s = PARITY;
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (fall_stb_r) begin
          par_s   = data_sync_r;
          state_s = STOP;
        end else begin
          state_s = PARITY;
        end
      end
      STOP: begin
        if (fall_stb_r) begin
          state_s = IDLE;
          if (data_sync_r && odd_parity_ok(shift_r, par_r)) begin
            stb_s  = 1'b1;
            byte_s = shift_r;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    // A stalled frame is abandoned; the partial byte is simply never reported.
    if (state_r == IDLE || fall_stb_r) begin
      wd_s = {WW{1'b0}};
    end else if (wd_r == WD_MAX) begin
      wd_s    = {WW{1'b0}};
      err_s   = 1'b1;
      state_s = IDLE;
    end else begin
      wd_s = wd_r + WW'(1);
    end
  end

  assign rx_stb  = stb_r;
  assign rx_byte = byte_r;
  assign rx_err  = err_r;

endmodule

// File: rtl/ps2_kbd_mmio_writer.sv
// Keyboard front end: decodes make/break sequences and publishes the held key
// into the memory-mapped keyboard word through a write/ack handshake.
module ps2_kbd_mmio_writer
  import ps2_kbd_pkg::*;
#(
  parameter logic [31:0] KBD_ADDR       = KBD_ADDR_DEFAULT,
  parameter int          FILTER_LEN     = 4,
  parameter int          TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic [7:0]  key_code,
  output logic        frame_err
);

  logic       rx_stb, rx_err;
  logic [7:0] rx_byte;

  logic       brk_r, brk_s, ext_r, ext_s;
  logic [7:0] key_r, key_s;
  logic       wr_s;
  logic [7:0] wval_s;
  logic       we_r;
  logic [31:0] wdata_r;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_stb   (rx_stb),
    .rx_byte  (rx_byte),
    .rx_err   (rx_err)
  );

  // Make/break decoder; the extended prefix is tracked but never alters the key value.
  always_comb begin
    brk_s  = brk_r;
    ext_s  = ext_r;
    key_s  = key_r;
    wr_s   = 1'b0;
    wval_s = 8'h00;
    if (rx_err) begin
      brk_s = 1'b0;
      ext_s = 1'b0;
    end else if (rx_stb) begin
      if (rx_byte == PS2_BREAK) begin
        brk_s = 1'b1;
      end else if (rx_byte == PS2_EXT) begin
        ext_s = 1'b1;
      end else begin
        brk_s = 1'b0;
        ext_s = 1'b0;
        if (!brk_r) begin
          if (rx_byte != key_r) begin
            key_s  = rx_byte;
            wr_s   = 1'b1;
            wval_s = rx_byte;
          end else begin
            key_s = key_r;
          end
        end else begin
          if (rx_byte == key_r) begin
            key_s  = 8'h00;
            wr_s   = 1'b1;
            wval_s = 8'h00;
          end else begin
            key_s = key_r;
          end
        end
      end
    end else begin
      key_s = key_r;
    end
  end

  // Decoder flags, held key and the write request; a fresh write always wins over an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      brk_r   <= 1'b0;
      ext_r   <= 1'b0;
      key_r   <= 8'h00;
      we_r    <= 1'b0;
      wdata_r <= 32'h0000_0000;
    end else begin
      brk_r <= brk_s;
      ext_r <= ext_s;
      key_r <= key_s;
      if (wr_s) begin
        we_r    <= 1'b1;
        wdata_r <= {24'h00_0000, wval_s};
      end else if (we_r && mem_ack) begin
        we_r <= 1'b0;
      end else begin
        we_r <= we_r;
      end
    end
  end

  assign mem_we    = we_r;
  assign mem_addr  = KBD_ADDR;
  assign mem_wdata = wdata_r;
  assign key_code  = key_r;
  assign frame_err = rx_err;

endmodule
